// File: rtl/tlp_wrr_scheduler.sv
// tlp_wrr_scheduler: packet-atomic weighted round-robin grant of the TLP transmit datapath
// across 4 requesters, with a watchdog that forcibly releases a stuck packet.
module tlp_wrr_scheduler #(
    parameter int WEIGHT_W    = 2,
    parameter int MAX_PKT_CYC = 64,
    parameter int CNT_W       = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            req,
    input  logic [4*WEIGHT_W-1:0] weight,
    input  logic                  beat_valid,
    input  logic                  eop,
    input  logic                  ready,
    output logic                  valid,
    output logic [1:0]            out_id,
    output logic [3:0]            grant,
    output logic                  timeout_err
);
    typedef enum logic {IDLE, GRANT} state_t;

    state_t            state_q, state_d;
    logic [1:0]        out_id_q, out_id_d, last_q, last_d, win, idx;
    logic [3:0]        grant_q, grant_d;
    logic              valid_q, valid_d, tmo_q, tmo_d;
    logic              found, done, tmo, keep, rot;
    logic [WEIGHT_W:0] credit_q, credit_d, reload;
    logic [CNT_W-1:0]  wdog_q, wdog_d;

    // Rotating search starts after the last winner and wraps back to it.
    always_comb begin
        found = 1'b0;
        win   = last_q;
        idx   = last_q;
        for (int k = 4; k >= 1; k--) begin
            idx = last_q + 2'(k);
            if (req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        done     = valid_q & beat_valid & ready & eop;
        tmo      = valid_q & ~done & (wdog_q == CNT_W'(MAX_PKT_CYC - 1));
        keep     = done & (credit_q > (WEIGHT_W+1)'(1)) & req[out_id_q];
        rot      = (state_q == IDLE) | done | tmo;
        reload   = {1'b0, weight[win*WEIGHT_W +: WEIGHT_W]} + {{WEIGHT_W{1'b0}}, 1'b1};
        state_d  = state_q;
        out_id_d = out_id_q;
        grant_d  = grant_q;
        valid_d  = valid_q;
        last_d   = last_q;
        credit_d = credit_q;
        wdog_d   = wdog_q + {{(CNT_W-1){1'b0}}, 1'b1};
        tmo_d    = tmo;
        if (keep) begin
            credit_d = credit_q - {{WEIGHT_W{1'b0}}, 1'b1};
            wdog_d   = '0;
        end else if (rot) begin
            state_d  = found ? GRANT : IDLE;
            valid_d  = found;
            out_id_d = found ? win : 2'd0;
            grant_d  = found ? 4'b0001 << win : 4'b0000;
            last_d   = found ? win : last_q;
            credit_d = found ? reload : credit_q;
            wdog_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            out_id_q <= 2'd0;
            grant_q  <= 4'b0000;
            valid_q  <= 1'b0;
            last_q   <= 2'd3;
            credit_q <= '0;
            wdog_q   <= '0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            out_id_q <= out_id_d;
            grant_q  <= grant_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            credit_q <= credit_d;
            wdog_q   <= wdog_d;
            tmo_q    <= tmo_d;
        end
    end

    assign valid       = valid_q;
    assign out_id      = out_id_q;
    assign grant       = grant_q;
    assign timeout_err = tmo_q;
endmodule

// File: tb/tb_tlp_wrr_scheduler.sv
// tb_tlp_wrr_scheduler: scoreboard bench; a packet-level reference model queues the expected
// outputs per cycle and an independent monitor compares them against the scheduler.
module tb_tlp_wrr_scheduler;
    localparam int MAXC = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req = '0;
    logic [7:0] weight = '0;
    logic       beat_valid = 1'b0, eop = 1'b0, ready = 1'b0;
    logic       valid, timeout_err;
    logic [1:0] out_id;
    logic [3:0] grant;

    int checks = 0, errors = 0;
    logic [7:0] expq[$];

    // Reference model: who owns the datapath, packets left in the turn, cycles in the packet.
    int m_own = -1, m_last = 3, m_cred = 0, m_age = 0;

    tlp_wrr_scheduler #(.WEIGHT_W(2), .MAX_PKT_CYC(MAXC), .CNT_W(3)) dut (
        .clk(clk), .reset(reset), .req(req), .weight(weight), .beat_valid(beat_valid),
        .eop(eop), .ready(ready), .valid(valid), .out_id(out_id), .grant(grant),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pack_exp(int own, bit t);
        logic [3:0] g;
        g = 4'b0001 << own;
        return (own < 0) ? {7'b0, t} : {1'b1, 2'(own), g, t};
    endfunction

    function automatic int pick(int from, logic [3:0] r);
        for (int k = 1; k <= 4; k++) if (r[(from + k) % 4]) return (from + k) % 4;
        return -1;
    endfunction

    task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %h expected %h ({valid,out_id,grant,timeout_err})",
                     name, $time, act, exp);
        end
    endtask

    task automatic step(logic [3:0] r, logic [7:0] w, bit bv, bit e, bit rd);
        int p;
        bit t, dn;
        @(negedge clk);
        req = r; weight = w; beat_valid = bv; eop = e; ready = rd;
        t  = 1'b0;
        dn = (m_own >= 0) && bv && rd && e;
        if (m_own < 0) begin
            p = pick(m_last, r);
            if (p >= 0) begin
                m_own = p; m_last = p; m_cred = int'(w[p*2 +: 2]) + 1; m_age = 0;
            end
        end else if (dn && m_cred > 1 && r[m_own]) begin
            m_cred--; m_age = 0;
        end else if (dn || m_age == MAXC - 1) begin
            t = !dn;
            p = pick(m_own, r);
            m_own = p; m_age = 0;
            if (p >= 0) begin
                m_last = p; m_cred = int'(w[p*2 +: 2]) + 1;
            end
        end else m_age++;
        expq.push_back(pack_exp(m_own, t));
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        if (expq.size() > 0) chk("sched", {valid, out_id, grant, timeout_err}, expq.pop_front());
    end

    initial begin
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_state", {valid, out_id, grant, timeout_err}, 8'h00);
        @(negedge clk);
        reset = 1'b1;
        for (int p = 0; p < 3; p++) for (int b = 0; b < 3; b++) step(4'b0100, 8'h00, 1, b == 2, 1);
        repeat (12) step(4'b1111, 8'h00, 1, 1, 1);
        step(4'b0000, 8'h00, 1, 1, 1);
        repeat (8) step(4'b0011, 8'h02, 1, 1, 1);
        repeat (3) step(4'b0010, 8'h02, 1, 1, 1);
        step(4'b0011, 8'h00, 1, 0, 1);
        repeat (5) step(4'b0011, 8'h00, 1, 1, 0);
        repeat (2) step(4'b0011, 8'h00, 1, 1, 1);
        repeat (20) step(4'b0011, 8'h00, 1, 0, 1);
        step(4'b0000, 8'h00, 1, 1, 1);
        step(4'b0001, 8'h00, 0, 0, 1);
        repeat (7) step(4'b0001, 8'h00, 1, 0, 1);
        step(4'b0001, 8'h00, 1, 1, 1);
        step(4'b0000, 8'h00, 1, 1, 1);
        // Asynchronous reset in the middle of a grant to requester 2.
        repeat (3) step(4'b0100, 8'h00, 1, 0, 1);
        @(posedge clk);
        #2;
        chk("pre_reset_grant", {valid, out_id, grant, timeout_err}, 8'b1_10_0100_0);
        reset = 1'b0;
        #1;
        chk("async_reset", {valid, out_id, grant, timeout_err}, 8'h00);
        m_own = -1; m_last = 3; m_cred = 0; m_age = 0;
        #1;
        reset = 1'b1;
        step(4'b0010, 8'h00, 1, 0, 1);
        step(4'b0010, 8'h00, 1, 1, 1);
        for (int i = 0; i < 1500; i++) begin
            if (i % 150 == 0) repeat (12) step(4'($urandom), 8'($urandom), 1, 0, 1);
            step(4'($urandom), 8'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 3) != 0);
        end
        repeat (2) @(posedge clk);
        #2;
        chk("queue_drained", 8'(expq.size()), 8'h00);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
